// File: rtl/vmem_pkg.sv
// vmem_pkg: state encoding and sizing helpers shared by vector_mem_sequencer and its read tracker.
package vmem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;
    localparam int N_DEF = 32;
    localparam int V_DEF = 256;
    localparam int BEATS_MAX = V_DEF / N_DEF;
    localparam int BPB = N_DEF / 8;
    localparam int CNT_W = $clog2(BEATS_MAX) + 1;
    function automatic int beatsMax(input int v, input int n);
        return v / n;
    endfunction
    function automatic int beatBytes(input int n);
        return n / 8;
    endfunction
    function automatic int cntWidth(input int v, input int n);
        return $clog2(v / n) + 1;
    endfunction
endpackage

// File: rtl/vmem_rd_tracker.sv
// vmem_rd_tracker: RD_LAT-deep {valid, beat index} pipeline naming the lane for each returning read.
module vmem_rd_tracker #(
    parameter int RD_LAT = 1,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issueValid,
    input  logic [IW-1:0] issueIdx,
    output logic          retValid,
    output logic [IW-1:0] retIdx
);
    logic [RD_LAT-1:0] validPipe;
    logic [IW-1:0]     idxPipe [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe <= '0;
            for (int i = 0; i < RD_LAT; i++) idxPipe[i] <= '0;
        end else begin
            validPipe[0] <= issueValid;
            idxPipe[0] <= issueIdx;
            for (int i = 1; i < RD_LAT; i++) begin
                validPipe[i] <= validPipe[i-1];
                idxPipe[i] <= idxPipe[i-1];
            end
        end
    end

    assign retValid = validPipe[RD_LAT-1];
    assign retIdx = idxPipe[RD_LAT-1];
endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: splits V-bit vector / N-bit scalar accesses into N-bit memory beats and stalls the pipeline meanwhile.
// Define ALIGN_CHECK_EN to reject misaligned requests with err instead of masking the low address bits.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int V = V_DEF,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_vector,
    input  logic           write,
    input  logic [N-1:0]   addr,
    input  logic [N-1:0]   wdata_s,
    input  logic [V-1:0]   wdata_v,
    input  logic [N-1:0]   ReadData,
    output logic [N-1:0]   AddressData,
    output logic [N/8-1:0] ByteenaData,
    output logic [N-1:0]   WriteData,
    output logic           RdenData,
    output logic           WrenData,
    output logic           Busy,
    output logic           done,
    output logic           err,
    output logic [N-1:0]   rdata_s,
    output logic [V-1:0]   rdata_v
);
    localparam int BEATS = beatsMax(V, N);
    localparam int CW = cntWidth(V, N);
    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [N-1:0] STRIDE = N'(beatBytes(N));
    localparam logic [N-1:0] VMASK = N'(V / 8 - 1);
    localparam logic [N-1:0] SMASK = N'(N / 8 - 1);

    stateT         state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] drainCnt;
    logic          isVec;
    logic          isWr;
    logic [V-1:0]  wdPend;
    logic          retValid;
    logic [CW-1:0] retIdx;
    logic [N-1:0]  alignMask;
    logic          reject;
    logic          lastBeat;
    logic [V-1:0]  startVec;

    assign alignMask = is_vector ? VMASK : SMASK;
`ifdef ALIGN_CHECK_EN
    assign reject = |(addr & alignMask);
`else
    assign reject = 1'b0;
`endif
    assign startVec = is_vector ? wdata_v : V'(wdata_s);
    assign lastBeat = cnt == (isVec ? CW'(BEATS - 1) : '0);
    assign Busy = state == ISSUE || state == DRAIN || (state == IDLE && start);

    // cnt always names the beat currently on the memory port, so it tags the tracker directly
    vmem_rd_tracker #(.RD_LAT(RD_LAT), .IW(CW)) tracker (
        .clk(clk),
        .rst(rst),
        .issueValid(RdenData),
        .issueIdx(cnt),
        .retValid(retValid),
        .retIdx(retIdx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            drainCnt <= '0;
            isVec <= 1'b0;
            isWr <= 1'b0;
            wdPend <= '0;
            AddressData <= '0;
            ByteenaData <= '0;
            WriteData <= '0;
            RdenData <= 1'b0;
            WrenData <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            rdata_s <= '0;
            rdata_v <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            if (retValid) begin
                if (isVec) rdata_v[int'(retIdx) * N +: N] <= ReadData;
                else rdata_s <= ReadData;
            end
            case (state)
                IDLE: if (start) begin
                    isVec <= is_vector;
                    isWr <= write;
                    cnt <= '0;
                    if (reject) begin
                        state <= DONE;
                        done <= 1'b1;
                        err <= 1'b1;
                    end else begin
                        state <= ISSUE;
                        AddressData <= addr & ~alignMask;
                        ByteenaData <= '1;
                        RdenData <= !write;
                        WrenData <= write;
                        WriteData <= write ? startVec[N-1:0] : '0;
                        wdPend <= startVec >> N;
                    end
                end
                ISSUE: if (lastBeat) begin
                    AddressData <= '0;
                    ByteenaData <= '0;
                    WriteData <= '0;
                    RdenData <= 1'b0;
                    WrenData <= 1'b0;
                    drainCnt <= '0;
                    state <= isWr ? DONE : DRAIN;
                    done <= isWr;
                end else begin
                    cnt <= cnt + CW'(1);
                    AddressData <= AddressData + STRIDE;
                    WriteData <= isWr ? wdPend[N-1:0] : '0;
                    wdPend <= wdPend >> N;
                end
                DRAIN: if (drainCnt == DW'(RD_LAT - 1)) begin
                    state <= DONE;
                    done <= 1'b1;
                end else begin
                    drainCnt <= drainCnt + DW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
